dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between the CPU load/store unit and the debugger.
- Fixed CPU priority, with a starvation limit that forces a debugger grant.
- Lock mode gives the debugger exclusive access while the core is halted.
- Sits between the CPU/debugger request buses and the DMEM macro; read data returns one cycle after grant.

Parameters:
ADDR_W, 10, memory word-address width
DATA_W, 32, data word width
MAX_WAIT, 8, consecutive lost contests before the debugger is forced to win (legal range 1..255)

Ports:
i_clk  in  1  clock, all state updates on posedge
i_rst_n  in  1  asynchronous active-low reset
i_cpu_req  in  1  CPU access request, held until granted
i_cpu_we  in  1  CPU write enable (1=write, 0=read)
i_cpu_addr  in  ADDR_W  CPU word address
i_cpu_wdata  in  DATA_W  CPU write data
o_cpu_gnt  out  1  CPU request accepted this cycle
o_cpu_rvalid  out  1  CPU read data valid
o_cpu_rdata  out  DATA_W  CPU read data
i_dbg_req  in  1  debugger access request, held until granted
i_dbg_we  in  1  debugger write enable (1=write, 0=read)
i_dbg_addr  in  ADDR_W  debugger word address
i_dbg_wdata  in  DATA_W  debugger write data
i_dbg_lock  in  1  debugger requests exclusive ownership
o_dbg_gnt  out  1  debugger request accepted this cycle
o_dbg_rvalid  out  1  debugger read data valid
o_dbg_rdata  out  DATA_W  debugger read data
o_locked  out  1  lock mode active
o_mem_en  out  1  memory access strobe
o_mem_we  out  1  memory write strobe
o_mem_addr  out  ADDR_W  memory address
o_mem_wdata  out  DATA_W  memory write data
i_mem_rdata  in  DATA_W  memory read data, valid the cycle after o_mem_en with o_mem_we=0

Behaviour:
- Reset (async, i_rst_n=0): state=NORMAL, wait_cnt=0, o_locked=0, both rvalid=0, both gnt=0, o_mem_en=0. All mem outputs are 0 when no grant is issued.
- Grants are combinational from requests, state and wait_cnt. At most one grant per cycle. A granted request is applied to the mem outputs in the same cycle.
- NORMAL state:
  - cpu_req only -> CPU granted.
  - dbg_req only -> debugger granted.
  - Both requesting -> CPU granted, unless wait_cnt==MAX_WAIT, in which case the debugger is granted.
- wait_cnt (8-bit), NORMAL only:
  - Increments when both request and the CPU is granted.
  - Clears when the debugger is granted or dbg_req is low.
  - Never exceeds MAX_WAIT.
- LOCK state:
  - o_cpu_gnt is forced to 0.
  - The debugger is granted whenever dbg_req=1.
  - wait_cnt is held at 0.
- Transitions, on the edge:
  - NORMAL->LOCK when i_dbg_lock=1.
  - LOCK->NORMAL when i_dbg_lock=0.
  - o_locked is the registered state.
  - A CPU grant in the same cycle that lock rises still completes.
- Read return:
  - rvalid is registered: o_x_rvalid=1 exactly one cycle after a granted read by that requester.
  - o_x_rdata = i_mem_rdata while o_x_rvalid=1, else 0.
  - Writes produce no rvalid.
- Back-to-back: a new grant may be issued in the same cycle as the previous read's rvalid (full throughput, 1 access/cycle).
- Reset during an outstanding read drops the pending rvalid; no response is issued after reset.
- Same-address contention is not special-cased; ordering is grant order.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs o_cpu_stall_cnt[15:0] and o_dbg_stall_cnt[15:0].
  - Each increments on cycles where that requester has req=1 and gnt=0, and saturates at 16'hFFFF.
  - Both reset to 0 and clear on input i_stats_clr (synchronous; clear wins over increment).
- Undefined: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg holds the state enum (ST_NORMAL, ST_LOCK), requester id constants (REQ_CPU=0, REQ_DBG=1), and the wait_cnt width constant.
- One sub-module is natural: dmem_arb_sat_cnt, a saturating counter with clear, instantiated twice under DMEM_ARB_STATS_EN.

Test Plan:
- Reset, then CPU read addr 0x005 (memory preloaded 0xDEADBEEF) -> o_cpu_gnt=1 same cycle; o_cpu_rvalid=1 with o_cpu_rdata=0xDEADBEEF next cycle; o_dbg_rvalid stays 0.
- CPU and debugger both request continuously, MAX_WAIT=8 -> CPU granted 8 cycles, debugger granted on the 9th, then pattern repeats; wait_cnt never exceeds 8.
- i_dbg_lock=1 with CPU requesting -> o_locked=1 next cycle; o_cpu_gnt=0 throughout; debugger write 0x3FF<=0x12345678 then read returns 0x12345678; lock drop -> CPU granted next cycle.
- Alternating CPU write/read to 0x010 every cycle -> one access per cycle; each rvalid aligns with the cycle after its read grant.
- Assert i_rst_n low the cycle after a debugger read grant -> o_dbg_rvalid stays 0, all outputs 0 asynchronously, state NORMAL after release.
- With DMEM_ARB_STATS_EN, 5 cycles of debugger blocked by lock-free CPU priority -> o_dbg_stall_cnt=5; i_stats_clr pulse -> 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants and helpers for the DMEM arbiter
//
// Holds the FSM state encodings, requester ids, the wait counter width and
// a saturating increment helper used by the starvation counter.
package dmem_arb_pkg;

    // Starvation counter width; MAX_WAIT must fit (legal range 1..255).
    localparam int WAIT_CNT_W = 8;

    // Arbiter states.
    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_LOCK   = 1'b1;

    // Requester ids, used to steer the memory bus mux.
    localparam logic [0:0] REQ_CPU = 1'b0;
    localparam logic [0:0] REQ_DBG = 1'b1;

    typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

    // Increment that never passes lim.
    function automatic wait_cnt_t wait_inc(input wait_cnt_t cnt, input wait_cnt_t lim);
        return (cnt >= lim) ? lim : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU/debugger request buses and DMEM macro bus
//
// Signals carry the arbiter-centric names: i_* are driven into the arbiter,
// o_* are driven by it.
//   slave  : arbiter side (inputs i_*, outputs o_*)
//   master : requesters + memory macro side
// Groups:
//   cpu : i_cpu_req/we/addr/wdata, o_cpu_gnt/rvalid/rdata
//   dbg : i_dbg_req/we/addr/wdata/lock, o_dbg_gnt/rvalid/rdata, o_locked
//   mem : o_mem_en/we/addr/wdata, i_mem_rdata
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              i_cpu_req;
    logic              i_cpu_we;
    logic [ADDR_W-1:0] i_cpu_addr;
    logic [DATA_W-1:0] i_cpu_wdata;
    logic              o_cpu_gnt;
    logic              o_cpu_rvalid;
    logic [DATA_W-1:0] o_cpu_rdata;

    logic              i_dbg_req;
    logic              i_dbg_we;
    logic [ADDR_W-1:0] i_dbg_addr;
    logic [DATA_W-1:0] i_dbg_wdata;
    logic              i_dbg_lock;
    logic              o_dbg_gnt;
    logic              o_dbg_rvalid;
    logic [DATA_W-1:0] o_dbg_rdata;
    logic              o_locked;

    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    modport slave (
        input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
        output o_cpu_gnt, o_cpu_rvalid, o_cpu_rdata,
        input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata, i_dbg_lock,
        output o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata, o_locked,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata
    );

    modport master (
        output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
        input  o_cpu_gnt, o_cpu_rvalid, o_cpu_rdata,
        output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata, i_dbg_lock,
        input  o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata, o_locked,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rdata
    );

endinterface

// File: rtl/dmem_arb_sat_cnt.sv
// rtl/dmem_arb_sat_cnt.sv - saturating up-counter with synchronous clear
//
// Ports:
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset
//   clr_i   : synchronous clear, wins over inc_i
//   inc_i   : count enable
//   cnt_o   : current count, sticks at all-ones
module dmem_arb_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debugger arbiter for the single-port DMEM macro
//
// Fixed CPU priority with a starvation limit (MAX_WAIT consecutive lost
// contests force a debugger grant) and a lock mode that gives the debugger
// exclusive access. Grants and the memory strobe are combinational from the
// requests; read data returns with a registered rvalid one cycle after grant.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : dmem_arbiter_if.slave (cpu, dbg and mem groups)
//   i_stats_clr, o_cpu_stall_cnt, o_dbg_stall_cnt :
//                    stall statistics, present only with DMEM_ARB_STATS_EN
//
// Build option: DMEM_ARB_STATS_EN adds the per-requester stall counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    dmem_arbiter_if.slave   bus
`ifdef DMEM_ARB_STATS_EN
    ,
    input  logic            i_stats_clr,
    output logic [15:0]     o_cpu_stall_cnt,
    output logic [15:0]     o_dbg_stall_cnt
`endif
);

    localparam wait_cnt_t WAIT_LIM = WAIT_CNT_W'(MAX_WAIT);

    logic [0:0]        state_q, state_d;
    wait_cnt_t         wait_cnt_q, wait_cnt_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;

    logic              cpu_gnt;
    logic              dbg_gnt;
    logic [0:0]        gnt_id;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Grant decision. Gating with i_rst_n keeps every grant and memory
    // strobe low for the whole reset window, not just after the first edge.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (i_rst_n) begin
            if (state_q == ST_LOCK) begin
                dbg_gnt = bus.i_dbg_req;
            end else if (bus.i_cpu_req && bus.i_dbg_req) begin
                if (wait_cnt_q == WAIT_LIM) begin
                    dbg_gnt = 1'b1;
                end else begin
                    cpu_gnt = 1'b1;
                end
            end else begin
                cpu_gnt = bus.i_cpu_req;
                dbg_gnt = bus.i_dbg_req;
            end
        end
    end

    // Memory bus mux: the winner drives the macro, everything is 0 when idle.
    always_comb begin
        gnt_id    = dbg_gnt ? REQ_DBG : REQ_CPU;
        mem_en    = cpu_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_en) begin
            if (gnt_id == REQ_DBG) begin
                mem_we    = bus.i_dbg_we;
                mem_addr  = bus.i_dbg_addr;
                mem_wdata = bus.i_dbg_wdata;
            end else begin
                mem_we    = bus.i_cpu_we;
                mem_addr  = bus.i_cpu_addr;
                mem_wdata = bus.i_cpu_wdata;
            end
        end
    end

    // Lock follows i_dbg_lock on every edge. A CPU grant issued in the cycle
    // lock rises was made under NORMAL rules, so it completes normally.
    always_comb begin
        state_d = bus.i_dbg_lock ? ST_LOCK : ST_NORMAL;
    end

    // Starvation counter counts consecutive debugger losses. It is cleared
    // on the way into LOCK so the debugger starts fresh after unlock.
    always_comb begin
        wait_cnt_d = '0;
        if ((state_q == ST_NORMAL) && (state_d == ST_NORMAL) &&
            bus.i_cpu_req && bus.i_dbg_req && cpu_gnt) begin
            wait_cnt_d = wait_inc(wait_cnt_q, WAIT_LIM);
        end
    end

    always_comb begin
        cpu_rvalid_d = cpu_gnt & ~bus.i_cpu_we;
        dbg_rvalid_d = dbg_gnt & ~bus.i_dbg_we;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_NORMAL;
            wait_cnt_q   <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
        end
    end

    assign bus.o_cpu_gnt    = cpu_gnt;
    assign bus.o_dbg_gnt    = dbg_gnt;
    assign bus.o_locked     = (state_q == ST_LOCK);
    assign bus.o_mem_en     = mem_en;
    assign bus.o_mem_we     = mem_we;
    assign bus.o_mem_addr   = mem_addr;
    assign bus.o_mem_wdata  = mem_wdata;
    assign bus.o_cpu_rvalid = cpu_rvalid_q;
    assign bus.o_dbg_rvalid = dbg_rvalid_q;
    // Read data is only exposed to the requester that owns the return slot.
    assign bus.o_cpu_rdata  = cpu_rvalid_q ? bus.i_mem_rdata : '0;
    assign bus.o_dbg_rdata  = dbg_rvalid_q ? bus.i_mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    dmem_arb_sat_cnt #(.W(16)) u_cpu_stall (
        .clk_i   (i_clk),
        .rst_n_i (i_rst_n),
        .clr_i   (i_stats_clr),
        .inc_i   (bus.i_cpu_req & ~cpu_gnt),
        .cnt_o   (o_cpu_stall_cnt)
    );

    dmem_arb_sat_cnt #(.W(16)) u_dbg_stall (
        .clk_i   (i_clk),
        .rst_n_i (i_rst_n),
        .clr_i   (i_stats_clr),
        .inc_i   (bus.i_dbg_req & ~dbg_gnt),
        .cnt_o   (o_dbg_stall_cnt)
    );
`endif

endmodule
